// File: rtl/fibo_pkg.sv
// Shared constants and types for the Fibonacci sequencing controller.
package fibo_pkg;

  localparam int FIBO_W = 4;

  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DEC  = 2'd2,
    DONE = 2'd3
  } fibo_state_t;

endpackage

// File: rtl/fibo_ctrl.sv
// Fibonacci controller driving an external ALU; FIBO_OVF_EN adds wrap tracking on overflow.
// Latency: done in cycle 2n+1 after the accepted start (cycle 1 for n=0); start is ignored while busy.
module fibo_ctrl
  import fibo_pkg::*;
#(
  parameter int WIDTH = FIBO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_d,
  input  logic             alu_zero
);

  fibo_state_t      state_q;
  logic [WIDTH-1:0] f0_q, f1_q, cnt_q, result_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [2:0]       alu_op_q;
  logic             busy_q, done_q;

`ifdef FIBO_OVF_EN
  logic tag0_q, tag1_q, ovf_q;
  logic wrap;

  // A carry out of an unsigned add shows up as a sum smaller than either operand.
  assign wrap     = (alu_d < f1_q);
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  // ALU operand registers are loaded with the values of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      f0_q     <= '0;
      f1_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= ALU_OP_ADD;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FIBO_OVF_EN
      tag0_q   <= 1'b0;
      tag1_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q    <= n;
            f0_q     <= '0;
            f1_q     <= WIDTH'(1);
            result_q <= '0;
            busy_q   <= 1'b1;
            alu_op_q <= ALU_OP_ADD;
            alu_a_q  <= '0;
`ifdef FIBO_OVF_EN
            tag0_q   <= 1'b0;
            tag1_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
            if (n == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              alu_b_q <= '0;
            end else begin
              state_q <= ADD;
              alu_b_q <= WIDTH'(1);
            end
          end
        end
        ADD: begin
          f0_q     <= f1_q;
          f1_q     <= alu_d;
`ifdef FIBO_OVF_EN
          tag0_q   <= tag1_q;
          tag1_q   <= tag1_q | wrap;
`endif
          state_q  <= DEC;
          alu_a_q  <= cnt_q;
          alu_b_q  <= WIDTH'(1);
          alu_op_q <= ALU_OP_SUB;
        end
        DEC: begin
          cnt_q    <= alu_d;
          alu_op_q <= ALU_OP_ADD;
          if (alu_zero) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= f0_q;
`ifdef FIBO_OVF_EN
            ovf_q    <= tag0_q;
`endif
            alu_a_q  <= '0;
            alu_b_q  <= '0;
          end else begin
            state_q <= ADD;
            alu_a_q <= f0_q;
            alu_b_q <= f1_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;

endmodule

// File: tb/tb_fibo_ctrl.sv
// Self-checking bench for fibo_ctrl with a behavioural 4-bit ALU beside it.
module tb_fibo_ctrl;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
`ifdef FIBO_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] n;
  logic       busy, done, overflow;
  logic [3:0] result, alu_a, alu_b, alu_d;
  logic [2:0] alu_op;
  logic       alu_zero;

  always #5 clk = ~clk;

  assign alu_d    = (alu_op == OP_SUB) ? alu_a - alu_b : alu_a + alu_b;
  assign alu_zero = (alu_d == 4'h0);

  fibo_ctrl #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .n        (n),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_d    (alu_d),
    .alu_zero (alu_zero)
  );

  typedef struct {
    logic [3:0] nv;
    logic [3:0] res;
    bit         ovf_m;
    int         cyc;
  } vec_t;

  typedef struct {
    logic [3:0] res;
    bit         ovf;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Drives one start from the current negedge and follows the run until one cycle past done.
  task automatic run(input logic [3:0] nv, input logic [3:0] res, input bit ovf_m,
                     input int cyc_exp, input int ign_at, input bit pulse_done);
    exp_t e;
    exp_t got;
    int   cyc = 0;
    bit   seen = 1'b0;
    int   seq_err = 0;
    logic [3:0] held;
    e.res = res;
    e.ovf = ovf_m & OVF_ON;
    e.cyc = cyc_exp;
    sb.push_back(e);
    start = 1'b1;
    n = nv;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 4'($urandom);
    while (!seen && cyc < 40) begin
      cyc++;
      @(negedge clk);
      if (ign_at != 0 && cyc == ign_at) begin
        start = 1'b1;
        n = 4'h2;
      end else if (ign_at != 0 && cyc == ign_at + 1) begin
        start = 1'b0;
      end
      if (busy !== 1'b1) seq_err++;
      if (done === 1'b1) begin
        seen = 1'b1;
        if (alu_op !== OP_ADD) seq_err++;
        got = sb.pop_front();
        chk($sformatf("result n=%0d", nv), result, got.res);
        chk($sformatf("overflow n=%0d", nv), overflow, got.ovf);
        chk($sformatf("done_cycle n=%0d", nv), cyc, got.cyc);
      end else if (cyc % 2 == 1) begin
        if (alu_op !== OP_ADD) seq_err++;
      end else begin
        if (alu_op !== OP_SUB || alu_b !== 4'h1) seq_err++;
      end
    end
    if (!seen) begin
      chk($sformatf("done_timeout n=%0d", nv), 0, 1);
      void'(sb.pop_front());
    end
    chk($sformatf("alu_seq/busy n=%0d", nv), seq_err, 0);
    held = result;
    if (pulse_done) begin
      start = 1'b1;
      n = 4'h1;
    end
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("done_pulse_width n=%0d", nv), done, 1'b0);
    chk($sformatf("busy_after_done n=%0d", nv), busy, 1'b0);
    chk($sformatf("result_held n=%0d", nv), result, held);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{nv: 4'd0,  res: 4'h0, ovf_m: 1'b0, cyc: 1};
    vecs[1] = '{nv: 4'd1,  res: 4'h1, ovf_m: 1'b0, cyc: 3};
    vecs[2] = '{nv: 4'd7,  res: 4'hD, ovf_m: 1'b0, cyc: 15};
    vecs[3] = '{nv: 4'd8,  res: 4'h5, ovf_m: 1'b1, cyc: 17};
    vecs[4] = '{nv: 4'd15, res: 4'h2, ovf_m: 1'b1, cyc: 31};
    vecs[5] = '{nv: 4'd12, res: 4'h0, ovf_m: 1'b1, cyc: 25};
    vecs[6] = '{nv: 4'd2,  res: 4'h1, ovf_m: 1'b0, cyc: 5};
    vecs[7] = '{nv: 4'd13, res: 4'h9, ovf_m: 1'b1, cyc: 27};

    rst_n = 1'b0;
    start = 1'b0;
    n     = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset result", result, 4'h0);
    chk("reset overflow", overflow, 1'b0);
    chk("reset alu_a", alu_a, 4'h0);
    chk("reset alu_b", alu_b, 4'h0);
    chk("reset alu_op", alu_op, OP_ADD);

    // Back-to-back: each run starts in the first IDLE cycle after the previous DONE.
    for (int i = 0; i < 8; i++)
      run(vecs[i].nv, vecs[i].res, vecs[i].ovf_m, vecs[i].cyc, 0, 1'b0);

    run(4'd5, 4'h5, 1'b0, 11, 5, 1'b0);
    run(4'd3, 4'h2, 1'b0, 7, 0, 1'b1);
    @(negedge clk);
    chk("start_in_done_ignored", busy, 1'b0);

    start = 1'b1;
    n = 4'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst busy", busy, 1'b0);
    chk("midrun_rst done", done, 1'b0);
    chk("midrun_rst result", result, 4'h0);
    chk("midrun_rst overflow", overflow, 1'b0);
    chk("midrun_rst alu_a", alu_a, 4'h0);
    chk("midrun_rst alu_b", alu_b, 4'h0);
    chk("midrun_rst alu_op", alu_op, OP_ADD);
    repeat (2) begin
      @(negedge clk);
      chk("midrun_rst no_done", done, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run(4'd3, 4'h2, 1'b0, 7, 0, 1'b0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
